// File: rtl/laser_ctrl_pkg.sv
// Shared constants, state encoding and saturating
// energy helpers for the laser controller.
package laser_ctrl_pkg;

  localparam int MAX_X = 384;
  localparam int MAX_Y = 448;

  localparam logic [11:0] C_GREEN = 12'h0F0;
  localparam logic [11:0] C_RED   = 12'hF00;
  localparam logic [11:0] C_NONE  = 12'h000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHARGE   = 2'd1,
    ST_FIRE     = 2'd2,
    ST_OVERHEAT = 2'd3
  } state_t;

  // Add with ceiling; 9-bit sum so the carry never wraps.
  function automatic logic [7:0] sat_add(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] lim
  );
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[7:0];
  endfunction

  // Subtract with floor at zero; borrow shows in bit 8.
  function automatic logic [7:0] sat_sub(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} - {1'b0, b};
    return s[8] ? 8'd0 : s[7:0];
  endfunction

endpackage

// File: rtl/laser_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous button
// levels; flops clear on synchronous reset.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw level through two flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/laser_ctrl.sv
// Laser gating FSM with warm-up, energy reserve,
// overheat lockout and a side-panel energy gauge.
module laser_ctrl
  import laser_ctrl_pkg::*;
#(
  parameter int E_MAX   = 255,
  parameter int DRAIN   = 4,
  parameter int REGEN   = 2,
  parameter int RESUME  = 128,
  parameter int WARMUP  = 3,
  parameter int GAUGE_X = 392,
  parameter int GAUGE_Y = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fire_btn,
  input  logic        frame_tick,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic        shooting,
  output logic        overheat,
  output logic [7:0]  energy,
  output logic        gauge_on,
  output logic [11:0] rgb_out
);

  localparam int WW =
    ($clog2(WARMUP) > 2) ? $clog2(WARMUP) : 2;

  localparam logic [7:0] EMAX_L  = 8'(E_MAX);
  localparam logic [7:0] DRAIN_L = 8'(DRAIN);
  localparam logic [7:0] REGEN_L = 8'(REGEN);
  localparam logic [7:0] RES_L   = 8'(RESUME);
  localparam logic [WW-1:0] WLAST = WW'(WARMUP - 1);

  localparam logic [10:0] GX0 = 11'(GAUGE_X);
  localparam logic [10:0] GX1 = 11'(GAUGE_X + 8);
  localparam logic [10:0] GYB = 11'(GAUGE_Y + 128);

  logic          fire_s;
  state_t        state, state_n;
  logic [WW-1:0] warm_cnt, warm_n;
  logic [7:0]    energy_n;
  logic [7:0]    e_regen, e_drain;

  sync2 u_sync_fire (
    .clk   (clk),
    .reset (reset),
    .d     (fire_btn),
    .q     (fire_s)
  );

  assign e_regen = sat_add(energy, REGEN_L, EMAX_L);
  assign e_drain = sat_sub(energy, DRAIN_L);

  // Register state, warm-up count, energy and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      warm_cnt <= '0;
      energy   <= EMAX_L;
      shooting <= 1'b0;
      overheat <= 1'b0;
    end else begin
      state    <= state_n;
      warm_cnt <= warm_n;
      energy   <= energy_n;
      shooting <= (state_n == ST_FIRE);
      overheat <= (state_n == ST_OVERHEAT);
    end
  end

  // Per-frame transitions and energy update.
  always_comb begin
    state_n  = state;
    warm_n   = warm_cnt;
    energy_n = energy;
    if (frame_tick) begin
      unique case (state)
        ST_IDLE: begin
          energy_n = e_regen;
          if (fire_s) begin
            state_n = ST_CHARGE;
            warm_n  = '0;
          end
        end
        ST_CHARGE: begin
          energy_n = e_regen;
          if (!fire_s)
            state_n = ST_IDLE;
          else if (warm_cnt == WLAST)
            state_n = ST_FIRE;
          else
            warm_n = warm_cnt + 1'b1;
        end
        ST_FIRE: begin
          energy_n = e_drain;
          if (e_drain == 8'd0)
            state_n = ST_OVERHEAT;
          else if (!fire_s)
            state_n = ST_IDLE;
        end
        ST_OVERHEAT: begin
          energy_n = e_regen;
          if (e_regen >= RES_L)
            state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  logic [10:0] xe, ye, h, ytop;

  // Bar grows upward from a fixed bottom row.
  always_comb begin
    xe       = {1'b0, x};
    ye       = {1'b0, y};
    h        = {4'b0, energy[7:1]};
    ytop     = GYB - h;
    gauge_on = (xe >= GX0) && (xe < GX1) &&
               (ye >= ytop) && (ye < GYB);
    rgb_out  = C_NONE;
    if (gauge_on)
      rgb_out = overheat ? C_RED : C_GREEN;
  end

endmodule
